fft_data_input_pp: RTL
======================

# fft_data_input_pp

Ping-pong frame buffer feeding the FFT core's AXI-Stream input. Software writes interleaved RE/IM samples into the fill bank through a RAM write port. A trigger commits that bank for streaming and swaps the write side, so the next frame loads while the current one streams. Sample width, FFT size and an optional bit-reversed output order are parametrised or runtime-selectable.

## Interface
- NFFT, 3, log2 of FFT points; POINT_SIZE = 2**NFFT
- DATA_WIDTH, 32, bits per RE or IM component
- N_ELEMENTS, 2*POINT_SIZE (derived), words per bank
- ADDR_W, clog2(N_ELEMENTS) (derived), element address width
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- wAddr  in  ADDR_W  element index in fill bank; even = RE of point wAddr>>1, odd = IM
- wData  in  DATA_WIDTH  write data
- wEn  in  1  write strobe, always targets the current fill bank
- trig  in  1  commit fill bank for streaming, single-cycle pulse
- bitrev  in  1  output order for the committed frame; sampled on trig accept
- tready  in  1  AXIS ready from FFT core
- tvalid  out  1  AXIS valid
- tlast  out  1  high on beat POINT_SIZE-1
- tdata  out  2*DATA_WIDTH  {IM, RE}
- streaming  out  1  a frame is being output (LOAD or STREAM state)
- fill_bank  out  1  bank index currently receiving writes
- trig_ready  out  1  a trig presented now is accepted
- drop_count  out  16  rejected triggers, saturating

## Operation
- Two banks of N_ELEMENTS x DATA_WIDTH RAM. Each bank is either FILL or COMMITTED; at most one bank is COMMITTED.
- trig_ready = 1 when no bank is COMMITTED.
- Accept = trig && trig_ready:
  - the fill bank becomes COMMITTED with its latched bitrev;
  - fill_bank toggles;
  - a write in the accept cycle lands in the old bank and is part of the frame.
- trig && !trig_ready: trigger ignored, drop_count += 1, saturating at 16'hFFFF.
- Streamer FSM:
  - IDLE: a COMMITTED bank exists -> LOAD, issue read of beat 0.
  - LOAD: registered RAM data -> tdata, tvalid=1 -> STREAM.
  - STREAM: on tvalid&&tready advance beat index i. If i was POINT_SIZE-1: bank returns to FILL state, tvalid=0, next state IDLE.
- Beat i reads point p = i, or bit-reverse(i) over NFFT bits when bitrev was latched 1. tdata = {ram[2p+1], ram[2p]}.
- AXIS rules:
  - tdata and tlast are held stable while tvalid && !tready.
  - tvalid never drops mid-frame.
  - Prefetch of beat i+1 must not stall throughput: 1 beat/clk under continuous tready.
- Writes never target the COMMITTED bank; no write lock is required.

## Timing
- Reset (resetn=0 at an edge):
  - tvalid=0, tlast=0, tdata=0, streaming=0, fill_bank=0, trig_ready=1, drop_count=0;
  - FSM returns to IDLE and both banks return to FILL;
  - RAM contents are retained, not cleared.
- Reset mid-frame: the frame is aborted; tvalid=0 after that edge and no tlast is emitted.
- Trig accepted at edge k with the FSM idle:
  - LOAD after edge k+1;
  - tvalid=1 with beat 0 after edge k+2;
  - streaming=1 from edge k+1 through the last handshake.
- trig_ready falls after edge k and rises after the edge that accepts the last beat. A new trig in that same cycle is rejected.
- With continuous tready, beats 0..POINT_SIZE-1 take POINT_SIZE consecutive cycles. tlast coincides with beat POINT_SIZE-1 only.
- trig and reset in the same cycle: reset wins and drop_count is not incremented.

## Test plan
- NFFT=3, DATA_WIDTH=32: fill bank 0 with ram[j]=j, trig, tready=1 -> tvalid 2 clocks after accept. tdata = {1,0},{3,2}…{15,14}; tlast only on beat 7. fill_bank=1.
- Same frame with bitrev=1 -> point order 0,4,2,6,1,5,3,7; beat 1 tdata={9,8}.
- tready toggling 1010… -> tdata/tlast stable while stalled. 8 handshakes, frame completes in 16 cycles.
- Write bank 1 with 100+j during frame 0 streaming, trig after frame 0 ends -> second frame outputs {101,100}… with no corruption of frame 0.
- 3 trigs during one streaming frame -> all rejected, drop_count=3. Force 70000 rejects -> drop_count holds 16'hFFFF.
- resetn=0 at beat 4 -> tvalid=0, streaming=0, trig_ready=1, fill_bank=0 after the edge. A following trig streams bank 0 from beat 0.

Source files
------------

// File: rtl/fft_data_input_pp_if.sv
// Bundle of the sample-write port, trigger controls and AXI-Stream output
// of the FFT input ping-pong buffer.
interface fft_data_input_pp_if #(
  parameter int NFFT       = 3,
  parameter int DATA_WIDTH = 32
);
  localparam int ADDR_W = $clog2(2 * (1 << NFFT));

  logic [ADDR_W-1:0]       wAddr;
  logic [DATA_WIDTH-1:0]   wData;
  logic                    wEn;
  logic                    trig;
  logic                    bitrev;
  logic                    tready;
  logic                    tvalid;
  logic                    tlast;
  logic [2*DATA_WIDTH-1:0] tdata;
  logic                    streaming;
  logic                    fill_bank;
  logic                    trig_ready;
  logic [15:0]             drop_count;

  modport master (
    output wAddr, wData, wEn, trig, bitrev, tready,
    input  tvalid, tlast, tdata, streaming, fill_bank, trig_ready, drop_count
  );

  modport slave (
    input  wAddr, wData, wEn, trig, bitrev, tready,
    output tvalid, tlast, tdata, streaming, fill_bank, trig_ready, drop_count
  );
endinterface

// File: rtl/fft_data_input_pp.sv
// Ping-pong frame buffer: software fills one bank while the other streams
// {IM, RE} beats to the FFT core, optionally in bit-reversed point order.
module fft_data_input_pp #(
  parameter int NFFT       = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  fft_data_input_pp_if.slave   bus
);
  localparam int POINT_SIZE = 1 << NFFT;
  localparam int N_ELEMENTS = 2 * POINT_SIZE;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_e;

  function automatic logic [NFFT-1:0] bit_reverse(input logic [NFFT-1:0] v);
    logic [NFFT-1:0] r;
    for (int b = 0; b < NFFT; b++) r[b] = v[NFFT-1-b];
    return r;
  endfunction

  logic [DATA_WIDTH-1:0]   mem_q [2][N_ELEMENTS];
  logic [2*DATA_WIDTH-1:0] rd_data_q;

  state_e                  state_q, state_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [2*DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [NFFT-1:0]         out_idx_q, out_idx_d;
  logic [NFFT-1:0]         rd_idx_q, rd_idx_d;
  logic                    fill_bank_q, fill_bank_d;
  logic                    committed_q, committed_d;
  logic                    commit_bitrev_q, commit_bitrev_d;
  logic [15:0]             drop_count_q, drop_count_d;

  logic                    accept;
  logic                    handshake;
  logic                    last_beat;
  logic                    frame_done;
  logic                    rd_en;
  logic [NFFT-1:0]         rd_point;

  always_comb begin
    accept     = bus.trig && !committed_q;
    handshake  = tvalid_q && bus.tready;
    last_beat  = (out_idx_q == NFFT'(POINT_SIZE - 1));
    frame_done = (state_q == STREAM) && handshake && last_beat;
    rd_point   = commit_bitrev_q ? bit_reverse(rd_idx_q) : rd_idx_q;

    fill_bank_d     = fill_bank_q ^ accept;
    commit_bitrev_d = accept ? bus.bitrev : commit_bitrev_q;
    committed_d     = committed_q;
    if (accept) committed_d = 1'b1;
    else if (frame_done) committed_d = 1'b0;

    drop_count_d = drop_count_q;
    if (bus.trig && committed_q && (drop_count_q != 16'hFFFF))
      drop_count_d = drop_count_q + 16'd1;
  end

  // rd_data_q always holds the beat after the one on tdata, so each
  // handshake can present the next beat without a bubble.
  always_comb begin
    state_d   = state_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    out_idx_d = out_idx_q;
    rd_idx_d  = rd_idx_q;
    rd_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (committed_q) begin
          state_d  = LOAD;
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      LOAD: begin
        state_d   = STREAM;
        tvalid_d  = 1'b1;
        tdata_d   = rd_data_q;
        tlast_d   = 1'b0;
        out_idx_d = '0;
        rd_en     = 1'b1;
        rd_idx_d  = rd_idx_q + 1'b1;
      end
      STREAM: begin
        if (handshake) begin
          if (last_beat) begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            rd_idx_d = '0;
          end else begin
            tdata_d   = rd_data_q;
            out_idx_d = out_idx_q + 1'b1;
            tlast_d   = (out_idx_q == NFFT'(POINT_SIZE - 2));
            rd_en     = 1'b1;
            rd_idx_d  = rd_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM is never reset; while a bank is committed it is always the
  // opposite of the fill bank, so reads use ~fill_bank_q.
  always_ff @(posedge clk) begin
    if (bus.wEn) mem_q[fill_bank_q][bus.wAddr] <= bus.wData;
    if (rd_en)
      rd_data_q <= {mem_q[~fill_bank_q][{rd_point, 1'b1}],
                    mem_q[~fill_bank_q][{rd_point, 1'b0}]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= IDLE;
      tvalid_q        <= 1'b0;
      tlast_q         <= 1'b0;
      tdata_q         <= '0;
      out_idx_q       <= '0;
      rd_idx_q        <= '0;
      fill_bank_q     <= 1'b0;
      committed_q     <= 1'b0;
      commit_bitrev_q <= 1'b0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      tvalid_q        <= tvalid_d;
      tlast_q         <= tlast_d;
      tdata_q         <= tdata_d;
      out_idx_q       <= out_idx_d;
      rd_idx_q        <= rd_idx_d;
      fill_bank_q     <= fill_bank_d;
      committed_q     <= committed_d;
      commit_bitrev_q <= commit_bitrev_d;
      drop_count_q    <= drop_count_d;
    end
  end

  assign bus.tvalid     = tvalid_q;
  assign bus.tlast      = tlast_q;
  assign bus.tdata      = tdata_q;
  assign bus.streaming  = (state_q != IDLE);
  assign bus.fill_bank  = fill_bank_q;
  assign bus.trig_ready = !committed_q;
  assign bus.drop_count = drop_count_q;
endmodule
